// File: rtl/tail_light_pkg.sv
// Shared types for the Thunderbird-style tail light controller: state
// encoding and the layout of the six-lamp vector.
package tail_light_pkg;

  // Dense 3-bit encoding: all eight codes are named states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_e;

  localparam int LAMP_W = 6;

  // Lamp vector layout, MSB first: {LC, LB, LA, RA, RB, RC}
  localparam int LC_BIT = 5;
  localparam int LB_BIT = 4;
  localparam int LA_BIT = 3;
  localparam int RA_BIT = 2;
  localparam int RB_BIT = 1;
  localparam int RC_BIT = 0;

  typedef logic [LAMP_W-1:0] lamp_vec_t;

  localparam lamp_vec_t LAMPS_OFF  = 6'b000_000;
  localparam lamp_vec_t LAMPS_L1   = 6'b001_000;
  localparam lamp_vec_t LAMPS_L2   = 6'b011_000;
  localparam lamp_vec_t LAMPS_L3   = 6'b111_000;
  localparam lamp_vec_t LAMPS_R1   = 6'b000_100;
  localparam lamp_vec_t LAMPS_R2   = 6'b000_110;
  localparam lamp_vec_t LAMPS_R3   = 6'b000_111;
  localparam lamp_vec_t LAMPS_ALL  = 6'b111_111;

endpackage

// File: rtl/tail_light_decode.sv
// Maps the controller state to the six-lamp drive vector.
module tail_light_decode
  import tail_light_pkg::*;
(
  input  state_e    state,
  output lamp_vec_t lamps
);

  // Pure state decode, no input dependence
  always_comb begin
    lamps = LAMPS_OFF;
    case (state)
      IDLE:    lamps = LAMPS_OFF;
      L1:      lamps = LAMPS_L1;
      L2:      lamps = LAMPS_L2;
      L3:      lamps = LAMPS_L3;
      R1:      lamps = LAMPS_R1;
      R2:      lamps = LAMPS_R2;
      R3:      lamps = LAMPS_R3;
      HAZ:     lamps = LAMPS_ALL;
      default: lamps = LAMPS_OFF;
    endcase
  end

endmodule

// File: rtl/tail_light_fsm.sv
// Moore turn-signal controller: outward sweep per side, hazard flash when
// both sides are requested. Requests are only looked at from IDLE.
module tail_light_fsm
  import tail_light_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  output logic LC,
  output logic LB,
  output logic LA,
  output logic RA,
  output logic RB,
  output logic RC
);

  state_e    state_r;
  state_e    state_next_s;
  lamp_vec_t lamps_s;

  // State register with synchronous reset to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a sweep in progress ignores both requests
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (left && right) begin
          state_next_s = HAZ;
        end else if (left) begin
          state_next_s = L1;
        end else if (right) begin
          state_next_s = R1;
        end else begin
          state_next_s = IDLE;
        end
      end
      L1:      state_next_s = L2;
      L2:      state_next_s = L3;
      L3:      state_next_s = IDLE;
      R1:      state_next_s = R2;
      R2:      state_next_s = R3;
      R3:      state_next_s = IDLE;
      HAZ:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  tail_light_decode u_decode (
    .state (state_r),
    .lamps (lamps_s)
  );

  // Output decode fans the lamp vector out to the individual drivers
  always_comb begin
    LC = lamps_s[LC_BIT];
    LB = lamps_s[LB_BIT];
    LA = lamps_s[LA_BIT];
    RA = lamps_s[RA_BIT];
    RB = lamps_s[RB_BIT];
    RC = lamps_s[RC_BIT];
  end

endmodule

// File: tb/tb_tail_light_fsm.sv
// Directed bench for tail_light_fsm; expected lamp vectors {LC,LB,LA,RA,RB,RC}
// are queued as each step is driven and checked after the following edge.
module tb_tail_light_fsm;

  logic clk;
  logic reset;
  logic left;
  logic right;
  logic LC, LB, LA, RA, RB, RC;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  logic [5:0] last_exp;
  logic       have_last;

  tail_light_fsm dut (
    .clk   (clk),
    .reset (reset),
    .left  (left),
    .right (right),
    .LC    (LC),
    .LB    (LB),
    .LA    (LA),
    .RA    (RA),
    .RB    (RB),
    .RC    (RC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] lamps_now();
    return {LC, LB, LA, RA, RB, RC};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one clock's worth of inputs away from the edge, then check the
  // post-edge lamps. Outputs must not follow the new inputs before the edge.
  task automatic step(input string tag, input logic rst, input logic l, input logic r,
                      input logic [5:0] exp);
    logic [5:0] got;
    @(negedge clk);
    reset = rst;
    left  = l;
    right = r;
    exp_q.push_back(exp);
    #1;
    if (have_last) begin
      check({tag, "_moore"}, lamps_now(), last_exp);
    end else begin
      have_last = 1'b0;
    end
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check(tag, lamps_now(), got);
    last_exp  = got;
    have_last = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    left      = 1'b0;
    right     = 1'b0;
    have_last = 1'b0;
    last_exp  = 6'b000_000;

    // Reset held for four edges, then two idle edges
    for (int i = 0; i < 4; i++) step("reset", 1'b1, 1'b0, 1'b0, 6'b000_000);
    for (int i = 0; i < 2; i++) step("idle", 1'b0, 1'b0, 1'b0, 6'b000_000);

    // Left for two edges; sweep completes after release
    step("left1", 1'b0, 1'b1, 1'b0, 6'b001_000);
    step("left2", 1'b0, 1'b1, 1'b0, 6'b011_000);
    step("left3", 1'b0, 1'b0, 1'b0, 6'b111_000);
    step("left4", 1'b0, 1'b0, 1'b0, 6'b000_000);

    // Right held for eight edges: period-4 repeat
    for (int i = 0; i < 2; i++) begin
      step("right1", 1'b0, 1'b0, 1'b1, 6'b000_100);
      step("right2", 1'b0, 1'b0, 1'b1, 6'b000_110);
      step("right3", 1'b0, 1'b0, 1'b1, 6'b000_111);
      step("right4", 1'b0, 1'b0, 1'b1, 6'b000_000);
    end

    // Both held: hazard alternates with idle
    for (int i = 0; i < 2; i++) begin
      step("haz_on",  1'b0, 1'b1, 1'b1, 6'b111_111);
      step("haz_off", 1'b0, 1'b1, 1'b1, 6'b000_000);
    end
    step("haz_rel", 1'b0, 1'b0, 1'b0, 6'b000_000);

    // Right pulse during the left sweep is lost
    step("mid_l1",   1'b0, 1'b1, 1'b0, 6'b001_000);
    step("mid_l2",   1'b0, 1'b0, 1'b0, 6'b011_000);
    step("mid_l3",   1'b0, 1'b0, 1'b1, 6'b111_000);
    step("mid_idle", 1'b0, 1'b0, 1'b0, 6'b000_000);
    step("mid_stay", 1'b0, 1'b0, 1'b0, 6'b000_000);

    // Reset from L2, held left restarts at L1
    step("rl_l1",  1'b0, 1'b1, 1'b0, 6'b001_000);
    step("rl_l2",  1'b0, 1'b1, 1'b0, 6'b011_000);
    step("rl_rst", 1'b1, 1'b1, 1'b0, 6'b000_000);
    step("rl_r1",  1'b0, 1'b1, 1'b0, 6'b001_000);
    step("rl_r2",  1'b0, 1'b1, 1'b0, 6'b011_000);
    step("rl_r3",  1'b0, 1'b0, 1'b0, 6'b111_000);
    step("rl_end", 1'b0, 1'b0, 1'b0, 6'b000_000);

    // Reset from R3 (with both requests high), held right restarts at R1
    step("rr_r1",  1'b0, 1'b0, 1'b1, 6'b000_100);
    step("rr_r2",  1'b0, 1'b0, 1'b1, 6'b000_110);
    step("rr_r3",  1'b0, 1'b0, 1'b1, 6'b000_111);
    step("rr_rst", 1'b1, 1'b1, 1'b1, 6'b000_000);
    step("rr_s1",  1'b0, 1'b0, 1'b1, 6'b000_100);
    step("rr_s2",  1'b0, 1'b0, 1'b0, 6'b000_110);
    step("rr_s3",  1'b0, 1'b0, 1'b0, 6'b000_111);
    step("rr_end", 1'b0, 1'b0, 1'b0, 6'b000_000);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
